noc_out_arbiter: RTL and testbench
==================================

NOC_OUT_ARBITER -- requirements
Module: noc_out_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of input ports competing for one output port (2..8).
REQ-002 Parameter MAX_CREDITS, default 4, downstream buffer depth in flits (1..15).
REQ-003 Parameter WD_CYCLES, default 16, watchdog stall limit in cycles (used only under REQ-029).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-port flit-pending flag.
REQ-007 last  input  NUM_REQ  per-port tail-flit marker, qualified by req.
REQ-008 credit_in  input  1  one-cycle pulse: downstream freed one slot.
REQ-009 grant  output  NUM_REQ  one-hot registered owner; all-zero when unowned.
REQ-010 select  output  $clog2(NUM_REQ)  owner index driving the output mux; 0 when unowned, never Z.
REQ-011 xfer  output  1  combinational: a flit moves this cycle.
REQ-012 credits  output  4  current downstream credit count.
REQ-013 credit_err  output  1  sticky: credit_in received while credits == MAX_CREDITS.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and LOCKED (owner held for a whole packet).
REQ-015 In IDLE, if any req bit is set and credits > 0, the block SHALL pick the first requester at or after rr_ptr (wrapping modulo NUM_REQ) and enter LOCKED next cycle, with grant/select registered to that port.
REQ-016 In IDLE with credits == 0, the block SHALL stay in IDLE regardless of req.
REQ-017 In IDLE, xfer SHALL be 0; arbitration costs exactly one cycle.
REQ-018 In LOCKED, xfer SHALL equal req[owner] && (credits > 0); other ports' req SHALL be ignored.
REQ-019 In LOCKED, when xfer && last[owner], the block SHALL return to IDLE next cycle, clear grant, and set rr_ptr to (owner+1) mod NUM_REQ.
REQ-020 In LOCKED, when req[owner] is low, the block SHALL hold ownership (wormhole lock); no preemption.
REQ-021 Credits SHALL decrement by 1 on xfer and increment by 1 on credit_in; when both occur in the same cycle, credits SHALL stay unchanged.
REQ-022 If credit_in arrives with credits == MAX_CREDITS and no xfer, credits SHALL saturate and credit_err SHALL set until reset.
REQ-023 A single-flit packet (req and last together on the first LOCKED cycle) SHALL occupy exactly 2 cycles: arbitrate, then transfer.
REQ-024 grant SHALL always be one-hot or zero; select SHALL equal the index of the set grant bit.

Reset
REQ-025 While reset is high: state = IDLE, grant = 0, select = 0, rr_ptr = 0, credits = MAX_CREDITS, credit_err = 0, xfer = 0.
REQ-026 Reset asserted mid-packet SHALL drop ownership immediately; the partial packet is discarded by the upstream logic.
REQ-027 credit_in during reset SHALL be ignored.

Configuration
REQ-028 Macro NOC_ARB_WATCHDOG_EN SHALL select whether the stall watchdog is compiled in.
REQ-029 With NOC_ARB_WATCHDOG_EN defined, the watchdog SHALL behave as follows:
- It counts consecutive LOCKED cycles without xfer.
- When the count reaches WD_CYCLES, the block SHALL force IDLE, advance rr_ptr past the owner, and pulse output wd_timeout high for 1 cycle.
- The count SHALL clear on any xfer or on leaving LOCKED.
REQ-030 Without the macro, neither the wd_timeout port nor the counter SHALL exist, and the lock SHALL be unbounded.

Structure
REQ-031 Shared package noc_arb_pkg SHALL hold the arb_state_t enum (IDLE, LOCKED) and a credit-width constant CRED_W = 4.
REQ-032 One combinational sub-module rr_pick SHALL take (req, ptr) and return the one-hot winner and its index.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, then req=3'b111 with single-flit packets (last=1) -> grants in order 0,1,2,0, each granted for 1 cycle, with 1 IDLE cycle between.
- req[1] sends a 3-flit packet while req[0] is held high -> grant stays 3'b010 for 3 xfers; port 0 is granted only after the tail.
- MAX_CREDITS=4 with no credit_in, port 2 sends 6 flits -> xfer stops after 4, credits=0, lock held; 2 credit_in pulses -> the remaining 2 flits transfer.
- xfer and credit_in in the same cycle with credits=2 -> credits stays 2; a credit_in at credits=4 -> credit_err=1 and stays set.
- Assert reset during the 2nd flit of a packet -> next cycle grant=0, credits=MAX_CREDITS, rr_ptr=0.
- With NOC_ARB_WATCHDOG_EN and WD_CYCLES=16, the owner drops req for 16 cycles -> wd_timeout pulses once and the next requester is granted.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC output-port arbiter.
package noc_arb_pkg;

  localparam int CRED_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/noc_out_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Wormhole output-port arbiter with credit flow control.
// Optional stall watchdog compiled in with NOC_ARB_WATCHDOG_EN.
module noc_out_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MAX_CREDITS = 4,
  parameter int WD_CYCLES   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         last,
  input  logic                       credit_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] select,
  output logic                       xfer,
  output logic [CRED_W-1:0]          credits,
  output logic                       credit_err
`ifdef NOC_ARB_WATCHDOG_EN
  ,
  output logic                       wd_timeout
`endif
);

  localparam int SEL_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               has_credit;
  logic               at_max;
  logic               tail_done;
  logic               wd_fire;
  logic               release_lock;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SEL_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign has_credit = (credits != '0);
  assign at_max     = (credits == CRED_W'(MAX_CREDITS));

  // Gated by reset so a packet cut by reset moves no further flits.
  assign xfer      = !reset && (state == LOCKED) && req[select] && has_credit;
  assign tail_done = xfer && last[select];
  assign next_ptr  = (select == SEL_W'(NUM_REQ - 1)) ? '0 : select + 1'b1;

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the WD_CYCLES-th consecutive locked cycle without a transfer.
  assign wd_fire = (state == LOCKED) && !xfer && (wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt     <= '0;
      wd_timeout <= 1'b0;
    end else begin
      wd_timeout <= wd_fire;
      if ((state != LOCKED) || xfer || wd_fire) wd_cnt <= '0;
      else                                      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign release_lock = tail_done || wd_fire;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      select <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any && has_credit) begin
            state  <= LOCKED;
            grant  <= pick_onehot;
            select <= pick_idx;
          end
        end
        LOCKED: begin
          if (release_lock) begin
            state  <= IDLE;
            grant  <= '0;
            select <= '0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A simultaneous transfer and returned credit cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits    <= CRED_W'(MAX_CREDITS);
      credit_err <= 1'b0;
    end else begin
      case ({xfer, credit_in})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (at_max) credit_err <= 1'b1;
          else        credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed scoreboard bench for noc_out_arbiter (default parameters).
module tb_noc_out_arbiter;

  localparam int N  = 3;
  localparam int MC = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic         credit_in;
  logic [N-1:0] grant;
  logic [1:0]   select;
  logic         xfer;
  logic [3:0]   credits;
  logic         credit_err;
`ifdef NOC_ARB_WATCHDOG_EN
  logic         wd_timeout;
`endif

  int checks;
  int errors;
  int exp_q[$];

  noc_out_arbiter #(
    .NUM_REQ     (N),
    .MAX_CREDITS (MC),
    .WD_CYCLES   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .last       (last),
    .credit_in  (credit_in),
    .grant      (grant),
    .select     (select),
    .xfer       (xfer),
    .credits    (credits),
    .credit_err (credit_err)
`ifdef NOC_ARB_WATCHDOG_EN
    ,
    .wd_timeout (wd_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each transferred flit must belong to the next expected owner.
  always @(negedge clk) begin
    int e;
    logic [N-1:0] eg;
    if (!reset) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL grant_onehot got=%b", grant);
      end
    end
    if (xfer) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer got grant=%b select=%0d expected no transfer", grant, select);
      end else begin
        e  = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        if (grant !== eg || select !== 2'(e)) begin
          errors++;
          $display("FAIL xfer_owner got grant=%b select=%0d expected grant=%b select=%0d",
                   grant, select, eg, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input int n);
    for (int i = 0; i < n; i++) begin
      credit_in = 1'b1;
      tick();
    end
    credit_in = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '1; last = '1; credit_in = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 3'b000 || select !== 2'd0 || xfer !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b select=%0d xfer=%b expected 000 0 0", grant, select, xfer);
    end
    checks++;
    if (credits !== 4'(MC) || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_credits got credits=%0d err=%b expected %0d 0", credits, credit_err, MC);
    end
    tick();
    reset = 1'b0; req = '0; credit_in = 1'b0;
    @(negedge clk);
    checks++;
    if (credits !== 4'(MC) || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_credit_ignored got credits=%0d err=%b expected %0d 0", credits, credit_err, MC);
    end
  endtask

  task automatic test_round_robin;
    tick();
    req = 3'b111; last = 3'b111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (xfer !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL rr_xfer_slot%0d got=%b expected=%b", i, xfer, (i % 2) == 1);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== 3'b000 || credits !== 4'd0) begin
        errors++;
        $display("FAIL rr_no_credit_idle got grant=%b credits=%0d expected 000 0", grant, credits);
      end
      tick();
    end
    req = '0;
    refill(4);
  endtask

  task automatic test_wormhole;
    int sent0 = 0;
    int sent1 = 0;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    for (int c = 0; c < 20 && !(sent1 == 3 && sent0 == 1); c++) begin
      req  = {1'b0, sent1 < 3, sent0 < 1};
      last = {1'b0, sent1 == 2, 1'b1};
      @(negedge clk);
      if (sent1 > 0 && sent1 < 3) begin
        checks++;
        if (grant !== 3'b010) begin
          errors++;
          $display("FAIL wormhole_hold got grant=%b expected 010", grant);
        end
      end
      if (xfer && grant[1]) sent1++;
      else if (xfer && grant[0]) sent0++;
      tick();
    end
    req = '0; last = '0;
    checks++;
    if (sent1 != 3 || sent0 != 1) begin
      errors++;
      $display("FAIL wormhole_done got p1=%0d p0=%0d expected 3 1", sent1, sent0);
    end
    refill(4);
  endtask

  task automatic test_credit_stall;
    int sent = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(2);
    for (int c = 0; c < 10; c++) begin
      req  = {sent < 6, 2'b00};
      last = {sent == 5, 2'b00};
      @(negedge clk);
      if (xfer) sent++;
      tick();
    end
    @(negedge clk);
    checks++;
    if (sent != 4 || credits !== 4'd0 || grant !== 3'b100 || xfer !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got sent=%0d credits=%0d grant=%b xfer=%b expected 4 0 100 0",
               sent, credits, grant, xfer);
    end
    tick();
    for (int c = 0; c < 12 && sent < 6; c++) begin
      credit_in = (c == 0 || c == 2);
      req  = {sent < 6, 2'b00};
      last = {sent == 5, 2'b00};
      @(negedge clk);
      if (xfer) sent++;
      tick();
    end
    credit_in = 1'b0; req = '0; last = '0;
    @(negedge clk);
    checks++;
    if (sent != 6 || credits !== 4'd0 || grant !== 3'b000) begin
      errors++;
      $display("FAIL stall_resume got sent=%0d credits=%0d grant=%b expected 6 0 000", sent, credits, grant);
    end
    tick();
  endtask

  task automatic test_credit_corner;
    refill(2);
    req = 3'b001; last = 3'b001;
    @(negedge clk);
    checks++;
    if (credits !== 4'd2 || xfer !== 1'b0) begin
      errors++;
      $display("FAIL corner_pre got credits=%0d xfer=%b expected 2 0", credits, xfer);
    end
    tick();
    credit_in = 1'b1;
    exp_q.push_back(0);
    @(negedge clk);
    checks++;
    if (xfer !== 1'b1) begin
      errors++;
      $display("FAIL corner_xfer got=%b expected 1", xfer);
    end
    tick();
    credit_in = 1'b0; req = '0; last = '0;
    @(negedge clk);
    checks++;
    if (credits !== 4'd2 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL corner_both got credits=%0d err=%b expected 2 0", credits, credit_err);
    end
    tick();
    refill(2);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    @(negedge clk);
    checks++;
    if (credit_err !== 1'b1 || credits !== 4'(MC)) begin
      errors++;
      $display("FAIL overflow got err=%b credits=%0d expected 1 %0d", credit_err, credits, MC);
    end
    tick(); tick(); tick();
    @(negedge clk);
    checks++;
    if (credit_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got=%b expected 1", credit_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet;
    req = 3'b010; last = 3'b000;
    exp_q.push_back(1);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (xfer !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_xfer got=%b expected 0", xfer);
    end
    tick();
    reset = 1'b0; req = 3'b111; last = 3'b111;
    @(negedge clk);
    checks++;
    if (grant !== 3'b000 || select !== 2'd0 || credits !== 4'(MC) || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state got grant=%b select=%0d credits=%0d err=%b expected 000 0 %0d 0",
               grant, select, credits, credit_err, MC);
    end
    exp_q.push_back(0);
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 3'b001 || xfer !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ptr got grant=%b xfer=%b expected 001 1", grant, xfer);
    end
    tick();
    req = '0; last = '0;
    tick();
  endtask

`ifdef NOC_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    int pulses = 0;
    int stalls = 0;
    bit done   = 1'b0;
    req = 3'b011; last = 3'b001;
    exp_q.push_back(1); exp_q.push_back(0);
    tick();
    tick();
    req = 3'b001;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wd_timeout) pulses++;
      if (grant == 3'b010 && !xfer) stalls++;
      if (xfer && grant[0]) done = 1'b1;
      tick();
    end
    req = '0; last = '0;
    checks++;
    if (pulses != 1 || stalls != 16 || !done) begin
      errors++;
      $display("FAIL watchdog got pulses=%0d stalls=%0d next_granted=%0b expected 1 16 1", pulses, stalls, done);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; req = '0; last = '0; credit_in = 1'b0;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_credit_corner();
    test_reset_mid_packet();
`ifdef NOC_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
